// File: rtl/s_axi_pkg.sv
// Shared response codes and FSM state types for the s_axi_regfile AXI4-Lite slave.
package s_axi_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_e;

endpackage

// File: rtl/s_axi_reg_bank.sv
// Register storage for s_axi_regfile: byte-strobed write port with a one-cycle
// write pulse per register, plus a combinational read mux.
module s_axi_reg_bank #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                   aclk_i,
  input  logic                   aresetn_i,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [31:0]            wr_data,
  input  logic [3:0]             wr_strb,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [31:0]            rd_data,
  output logic [NUM_REGS*32-1:0] regs,
  output logic [NUM_REGS-1:0]    reg_wr
);

  logic [31:0] regs_q [NUM_REGS];

  // The pulse fires on every in-range commit, even when no strobe bit is set.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
      reg_wr <= '0;
    end else begin
      reg_wr <= '0;
      if (wr_en) begin
        reg_wr[wr_idx] <= 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (wr_strb[b]) regs_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_idx} < (IDX_W+1)'(NUM_REGS)) rd_data = regs_q[rd_idx];
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs[32*k +: 32] = regs_q[k];
  end

endmodule

// File: rtl/s_axi_regfile.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers to the fabric.
// Define S_AXI_PROT_CHECK_EN to reject unprivileged (prot[0]=0) accesses with SLVERR.
module s_axi_regfile
  import s_axi_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 32
) (
  input  logic                   aclk_i,
  input  logic                   aresetn_i,
  input  logic                   awvalid_i,
  output logic                   awready_o,
  input  logic [ADDR_W-1:0]      awaddr_i,
  input  logic [2:0]             awprot_i,
  input  logic                   wvalid_i,
  output logic                   wready_o,
  input  logic [31:0]            wdata_i,
  input  logic [3:0]             wstrb_i,
  output logic                   bvalid_o,
  input  logic                   bready_i,
  output logic [1:0]             bresp_o,
  input  logic                   arvalid_i,
  output logic                   arready_o,
  input  logic [ADDR_W-1:0]      araddr_i,
  input  logic [2:0]             arprot_i,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [31:0]            rdata_o,
  output logic [1:0]             rresp_o,
  output logic [NUM_REGS*32-1:0] regs_o,
  output logic [NUM_REGS-1:0]    reg_wr_o
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS*4);

  wr_state_e        w_state;
  rd_state_e        r_state;
  logic [IDX_W-1:0] aw_idx_q;
  logic             aw_err_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             aw_hs, w_hs, ar_hs, commit;
  logic             aw_err_now, ar_err_now;
  logic [IDX_W-1:0] commit_idx;
  logic             commit_err;
  logic [31:0]      commit_data;
  logic [3:0]       commit_strb;
  logic [31:0]      rd_data;
  logic             unused_prot;

  assign unused_prot = ^{awprot_i, arprot_i};

`ifdef S_AXI_PROT_CHECK_EN
  assign aw_err_now = (awaddr_i >= ADDR_LIMIT) | ~awprot_i[0];
  assign ar_err_now = (araddr_i >= ADDR_LIMIT) | ~arprot_i[0];
`else
  assign aw_err_now = (awaddr_i >= ADDR_LIMIT);
  assign ar_err_now = (araddr_i >= ADDR_LIMIT);
`endif

  assign aw_hs = awvalid_i & awready_o;
  assign w_hs  = wvalid_i & wready_o;
  assign ar_hs = arvalid_i & arready_o;

  // Commit on the edge where the second half of the AW/W pair arrives;
  // whichever half came first is taken from its latch.
  always_comb begin
    commit = 1'b0;
    unique case (w_state)
      W_IDLE:  commit = aw_hs & w_hs;
      W_ADDR:  commit = w_hs;
      W_DATA:  commit = aw_hs;
      default: commit = 1'b0;
    endcase
  end

  assign commit_idx  = (w_state == W_ADDR) ? aw_idx_q : awaddr_i[2 +: IDX_W];
  assign commit_err  = (w_state == W_ADDR) ? aw_err_q : aw_err_now;
  assign commit_data = (w_state == W_DATA) ? wdata_q  : wdata_i;
  assign commit_strb = (w_state == W_DATA) ? wstrb_q  : wstrb_i;

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      w_state   <= W_IDLE;
      awready_o <= 1'b0;
      wready_o  <= 1'b0;
      bvalid_o  <= 1'b0;
      bresp_o   <= OKAY;
      aw_idx_q  <= '0;
      aw_err_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (commit) begin
        bvalid_o <= 1'b1;
        bresp_o  <= commit_err ? SLVERR : OKAY;
      end
      unique case (w_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            w_state   <= W_RESP;
            awready_o <= 1'b0;
            wready_o  <= 1'b0;
          end else if (aw_hs) begin
            aw_idx_q  <= awaddr_i[2 +: IDX_W];
            aw_err_q  <= aw_err_now;
            w_state   <= W_ADDR;
            awready_o <= 1'b0;
            wready_o  <= 1'b1;
          end else if (w_hs) begin
            wdata_q   <= wdata_i;
            wstrb_q   <= wstrb_i;
            w_state   <= W_DATA;
            awready_o <= 1'b1;
            wready_o  <= 1'b0;
          end else begin
            awready_o <= 1'b1;
            wready_o  <= 1'b1;
          end
        end
        W_ADDR: if (w_hs) begin
          w_state  <= W_RESP;
          wready_o <= 1'b0;
        end
        W_DATA: if (aw_hs) begin
          w_state   <= W_RESP;
          awready_o <= 1'b0;
        end
        W_RESP: if (bready_i) begin
          w_state   <= W_IDLE;
          bvalid_o  <= 1'b0;
          awready_o <= 1'b1;
          wready_o  <= 1'b1;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read data is sampled from the bank before any same-edge write lands.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_state   <= R_IDLE;
      arready_o <= 1'b0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      rresp_o   <= OKAY;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state   <= R_RESP;
            arready_o <= 1'b0;
            rvalid_o  <= 1'b1;
            rdata_o   <= ar_err_now ? 32'h0 : rd_data;
            rresp_o   <= ar_err_now ? SLVERR : OKAY;
          end else begin
            arready_o <= 1'b1;
          end
        end
        R_RESP: if (rready_i) begin
          r_state   <= R_IDLE;
          rvalid_o  <= 1'b0;
          arready_o <= 1'b1;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  s_axi_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_bank (
    .aclk_i    (aclk_i),
    .aresetn_i (aresetn_i),
    .wr_en     (commit & ~commit_err),
    .wr_idx    (commit_idx),
    .wr_data   (commit_data),
    .wr_strb   (commit_strb),
    .rd_idx    (araddr_i[2 +: IDX_W]),
    .rd_data   (rd_data),
    .regs      (regs_o),
    .reg_wr    (reg_wr_o)
  );

endmodule

// File: tb/tb_s_axi_regfile.sv
// Self-checking bench for s_axi_regfile: directed scenarios plus randomized
// traffic checked against a register-array reference model.
module tb_s_axi_regfile;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 32;
`ifdef S_AXI_PROT_CHECK_EN
  localparam bit PROT_CHECK = 1'b1;
`else
  localparam bit PROT_CHECK = 1'b0;
`endif

  logic                   aclk = 1'b0;
  logic                   aresetn = 1'b0;
  logic                   awvalid = 1'b0, awready;
  logic [ADDR_W-1:0]      awaddr = '0;
  logic [2:0]             awprot = '0;
  logic                   wvalid = 1'b0, wready;
  logic [31:0]            wdata = '0;
  logic [3:0]             wstrb = '0;
  logic                   bvalid, bready = 1'b0;
  logic [1:0]             bresp;
  logic                   arvalid = 1'b0, arready;
  logic [ADDR_W-1:0]      araddr = '0;
  logic [2:0]             arprot = '0;
  logic                   rvalid, rready = 1'b0;
  logic [31:0]            rdata;
  logic [1:0]             rresp;
  logic [NUM_REGS*32-1:0] regs;
  logic [NUM_REGS-1:0]    reg_wr;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [NUM_REGS];

  always #5 aclk = ~aclk;

  s_axi_regfile #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .aclk_i(aclk), .aresetn_i(aresetn),
    .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr), .awprot_i(awprot),
    .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata), .wstrb_i(wstrb),
    .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp),
    .arvalid_i(arvalid), .arready_o(arready), .araddr_i(araddr), .arprot_i(arprot),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rresp_o(rresp),
    .regs_o(regs), .reg_wr_o(reg_wr)
  );

  function automatic logic [31:0] reg_of(input int k);
    return regs[32*k +: 32];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old & ~mask) | (data & mask);
  endfunction

  function automatic logic [NUM_REGS-1:0] onehot(input int k);
    logic [NUM_REGS-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [NUM_REGS*32-1:0] model_flat();
    logic [NUM_REGS*32-1:0] v;
    for (int k = 0; k < NUM_REGS; k++) v[32*k +: 32] = model[k];
    return v;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [2:0] prot, output logic [1:0] resp,
                           output logic [NUM_REGS-1:0] pulse, output logic [NUM_REGS-1:0] pulse_after,
                           output bit timeout);
    bit aw_done, w_done, aw_go, w_go;
    int n;
    awaddr = addr; awprot = prot; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    aw_done = 0; w_done = 0; n = 0; timeout = 0;
    resp = 2'b11; pulse = '0; pulse_after = '0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(posedge aclk); #1;
      n++;
      if (aw_go) begin aw_done = 1; awvalid = 1'b0; end
      if (w_go)  begin w_done = 1;  wvalid = 1'b0; end
    end
    if (!(aw_done && w_done)) begin
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; timeout = 1;
      return;
    end
    pulse = reg_wr;
    resp  = bresp;
    if (bvalid !== 1'b1) timeout = 1;
    @(posedge aclk); #1;
    pulse_after = reg_wr;
    bready = 1'b0;
    if (bvalid !== 1'b0) timeout = 1;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [2:0] prot,
                          output logic [31:0] data, output logic [1:0] resp, output bit timeout);
    bit go;
    int n;
    araddr = addr; arprot = prot; arvalid = 1'b1; rready = 1'b1;
    timeout = 1; data = '0; resp = 2'b11; n = 0;
    while (arvalid && n < 20) begin
      go = arready;
      @(posedge aclk); #1;
      n++;
      if (go) arvalid = 1'b0;
    end
    if (arvalid) begin
      arvalid = 1'b0; rready = 1'b0;
      return;
    end
    if (rvalid === 1'b1) begin
      timeout = 0; data = rdata; resp = rresp;
    end
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    #23;
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      failures++; $display("[TB] FAIL reset_ready got=%b exp=000", {awready, wready, arready});
    end
    checks++;
    if ({bvalid, rvalid, reg_wr} !== '0 || regs !== '0) begin
      failures++; $display("[TB] FAIL reset_state bvalid=%b rvalid=%b reg_wr=%h regs_nonzero=%b exp all 0",
                           bvalid, rvalid, reg_wr, |regs);
    end
    checks++;
    if ({rdata, bresp, rresp} !== '0) begin
      failures++; $display("[TB] FAIL reset_resp rdata=%h bresp=%b rresp=%b exp 0", rdata, bresp, rresp);
    end
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      failures++; $display("[TB] FAIL release_ready got=%b exp=111", {awready, wready, arready});
    end
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
  endtask

  task automatic test_write_same_cycle();
    logic [1:0] resp; logic [NUM_REGS-1:0] p, pa; bit to;
    axi_write(32'h04, 32'hDEADBEEF, 4'hF, 3'b001, resp, p, pa, to);
    model[1] = 32'hDEADBEEF;
    checks++;
    if (to || resp !== 2'b00) begin
      failures++; $display("[TB] FAIL wr_same bresp got=%b timeout=%0d exp=00", resp, to);
    end
    checks++;
    if (p !== onehot(1) || pa !== '0) begin
      failures++; $display("[TB] FAIL wr_same_pulse got=%h then %h exp=%h then 0", p, pa, onehot(1));
    end
    checks++;
    if (reg_of(1) !== 32'hDEADBEEF) begin
      failures++; $display("[TB] FAIL wr_same_reg1 got=%h exp=deadbeef", reg_of(1));
    end
  endtask

  task automatic test_write_data_first();
    logic [1:0] resp; logic [NUM_REGS-1:0] p, pa; bit to;
    axi_write(32'h08, 32'hFFFFFFFF, 4'hF, 3'b001, resp, p, pa, to);
    model[2] = 32'hFFFFFFFF;
    wdata = 32'h12345678; wstrb = 4'h3; wvalid = 1'b1; bready = 1'b0;
    checks++;
    if (wready !== 1'b1) begin
      failures++; $display("[TB] FAIL dfirst_wready got=%b exp=1", wready);
    end
    @(posedge aclk); #1;
    wvalid = 1'b0;
    repeat (2) begin @(posedge aclk); #1; end
    checks++;
    if (bvalid !== 1'b0 || reg_of(2) !== 32'hFFFFFFFF || reg_wr !== '0) begin
      failures++; $display("[TB] FAIL dfirst_early bvalid=%b reg2=%h reg_wr=%h exp 0/ffffffff/0", bvalid, reg_of(2), reg_wr);
    end
    awaddr = 32'h08; awprot = 3'b001; awvalid = 1'b1;
    checks++;
    if (awready !== 1'b1) begin
      failures++; $display("[TB] FAIL dfirst_awready got=%b exp=1", awready);
    end
    @(posedge aclk); #1;
    awvalid = 1'b0;
    model[2] = merge(model[2], 32'h12345678, 4'h3);
    checks++;
    if (reg_of(2) !== model[2] || reg_wr !== onehot(2) || bvalid !== 1'b1 || bresp !== 2'b00) begin
      failures++; $display("[TB] FAIL dfirst_commit reg2=%h reg_wr=%h bvalid=%b bresp=%b exp %h/%h/1/00",
                           reg_of(2), reg_wr, bvalid, bresp, model[2], onehot(2));
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge aclk); #1;
      checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
        failures++; $display("[TB] FAIL bvalid_hold cycle %0d bvalid=%b bresp=%b exp 1/00", i, bvalid, bresp);
      end
    end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin
      failures++; $display("[TB] FAIL bvalid_drop got=%b exp=0", bvalid);
    end
  endtask

  task automatic test_read_stall();
    logic [31:0] first;
    araddr = 32'h04; arprot = 3'b001; arvalid = 1'b1; rready = 1'b0;
    checks++;
    if (arready !== 1'b1) begin
      failures++; $display("[TB] FAIL stall_arready got=%b exp=1", arready);
    end
    @(posedge aclk); #1;
    arvalid = 1'b0;
    first = rdata;
    checks++;
    if (rvalid !== 1'b1 || rdata !== model[1] || rresp !== 2'b00) begin
      failures++; $display("[TB] FAIL stall_read rvalid=%b rdata=%h rresp=%b exp 1/%h/00", rvalid, rdata, rresp, model[1]);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk); #1;
      checks++;
      if (rvalid !== 1'b1 || rdata !== first || rresp !== 2'b00) begin
        failures++; $display("[TB] FAIL rdata_hold cycle %0d rvalid=%b rdata=%h exp 1/%h", i, rvalid, rdata, first);
      end
    end
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      failures++; $display("[TB] FAIL stall_accept rvalid=%b arready=%b exp 0/1", rvalid, arready);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [NUM_REGS-1:0] p, pa; bit to; logic [31:0] d;
    axi_write(NUM_REGS*4, 32'h5A5A5A5A, 4'hF, 3'b001, resp, p, pa, to);
    checks++;
    if (to || resp !== 2'b10 || p !== '0) begin
      failures++; $display("[TB] FAIL oor_write bresp=%b pulse=%h timeout=%0d exp 10/0", resp, p, to);
    end
    checks++;
    if (regs !== model_flat()) begin
      failures++; $display("[TB] FAIL oor_regs got=%h exp=%h", regs, model_flat());
    end
    axi_read(NUM_REGS*4, 3'b001, d, resp, to);
    checks++;
    if (to || d !== 32'h0 || resp !== 2'b10) begin
      failures++; $display("[TB] FAIL oor_read rdata=%h rresp=%b timeout=%0d exp 0/10", d, resp, to);
    end
    axi_read(32'hFFFFFFFC, 3'b001, d, resp, to);
    checks++;
    if (to || d !== 32'h0 || resp !== 2'b10) begin
      failures++; $display("[TB] FAIL oor_read_top rdata=%h rresp=%b exp 0/10", d, resp);
    end
  endtask

  task automatic test_concurrent();
    logic [1:0] resp; logic [NUM_REGS-1:0] p, pa; bit to;
    axi_write(32'h0C, 32'h1, 4'hF, 3'b001, resp, p, pa, to);
    model[3] = 32'h1;
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      failures++; $display("[TB] FAIL conc_ready got=%b exp=111", {awready, wready, arready});
    end
    awaddr = 32'h0C; awprot = 3'b001; wdata = 32'h2; wstrb = 4'hF; araddr = 32'h0C; arprot = 3'b001;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== model[3] || rresp !== 2'b00) begin
      failures++; $display("[TB] FAIL conc_old rdata=%h rvalid=%b exp %h/1", rdata, rvalid, model[3]);
    end
    model[3] = 32'h2;
    checks++;
    if (reg_of(3) !== model[3] || bvalid !== 1'b1) begin
      failures++; $display("[TB] FAIL conc_new reg3=%h bvalid=%b exp %h/1", reg_of(3), bvalid, model[3]);
    end
    @(posedge aclk); #1;
    bready = 1'b0; rready = 1'b0;
  endtask

  task automatic test_reset_mid();
    awaddr = 32'h14; awprot = 3'b001; awvalid = 1'b1;
    araddr = 32'h04; arprot = 3'b001; arvalid = 1'b1; rready = 1'b0;
    @(posedge aclk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({rvalid, bvalid, awready, wready, arready} !== 5'b0 || regs !== '0) begin
      failures++; $display("[TB] FAIL mid_reset rvalid=%b bvalid=%b ready=%b regs_nonzero=%b exp all 0",
                           rvalid, bvalid, {awready, wready, arready}, |regs);
    end
    @(negedge aclk); aresetn = 1'b1;
    @(posedge aclk); #1;
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    wdata = 32'hAAAA5555; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || reg_wr !== '0 || reg_of(5) !== 32'h0) begin
      failures++; $display("[TB] FAIL mid_stale bvalid=%b reg_wr=%h reg5=%h exp 0/0/0", bvalid, reg_wr, reg_of(5));
    end
    awaddr = 32'h18; awvalid = 1'b1; bready = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    model[6] = 32'hAAAA5555;
    checks++;
    if (regs !== model_flat() || reg_wr !== onehot(6)) begin
      failures++; $display("[TB] FAIL mid_after reg6=%h reg5=%h reg_wr=%h exp %h/0/%h",
                           reg_of(6), reg_of(5), reg_wr, model[6], onehot(6));
    end
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] resp; logic [NUM_REGS-1:0] p, pa; bit to, ok;
    logic [31:0] addr, data, d; logic [3:0] strb; logic [2:0] prot; int idx;
    for (int i = 0; i < 60; i++) begin
      idx  = $urandom_range(0, NUM_REGS + 1);
      addr = 32'(idx * 4) + 32'($urandom_range(0, 3));
      prot = 3'($urandom_range(0, 7));
      ok   = (idx < NUM_REGS) && (!PROT_CHECK || prot[0]);
      if ($urandom_range(0, 1) == 0) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        axi_write(addr, data, strb, prot, resp, p, pa, to);
        if (ok) model[idx] = merge(model[idx], data, strb);
        checks++;
        if (to || resp !== (ok ? 2'b00 : 2'b10) || p !== (ok ? onehot(idx) : '0) || pa !== '0
            || regs !== model_flat()) begin
          failures++; $display("[TB] FAIL rand_wr %0d addr=%h bresp=%b pulse=%h timeout=%0d exp resp=%b pulse=%h; reg_ok=%b",
                               i, addr, resp, p, to, ok ? 2'b00 : 2'b10, ok ? onehot(idx) : '0, regs === model_flat());
        end
      end else begin
        axi_read(addr, prot, d, resp, to);
        checks++;
        if (to || d !== (ok ? model[idx] : 32'h0) || resp !== (ok ? 2'b00 : 2'b10)) begin
          failures++; $display("[TB] FAIL rand_rd %0d addr=%h rdata=%h rresp=%b timeout=%0d exp %h/%b",
                               i, addr, d, resp, to, ok ? model[idx] : 32'h0, ok ? 2'b00 : 2'b10);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int edges, first_hs, last_hs, done; bit go;
    awprot = 3'b001; wstrb = 4'hF; awaddr = 32'(8 * 4); wdata = $urandom;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    edges = 0; done = 0; first_hs = 0; last_hs = 0;
    while (done < 4 && edges < 40) begin
      go = awready && wready;
      @(posedge aclk); #1;
      edges++;
      if (go) begin
        model[8 + done] = wdata;
        checks++;
        if (reg_of(8 + done) !== model[8 + done] || reg_wr !== onehot(8 + done)) begin
          failures++; $display("[TB] FAIL b2b_wr %0d reg=%h reg_wr=%h exp %h/%h",
                               done, reg_of(8 + done), reg_wr, model[8 + done], onehot(8 + done));
        end
        if (done == 0) first_hs = edges;
        last_hs = edges;
        done++;
        if (done < 4) begin awaddr = 32'((8 + done) * 4); wdata = $urandom; end
      end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge aclk); #1;
    bready = 1'b0;
    checks++;
    if (done != 4 || last_hs - first_hs != 6) begin
      failures++; $display("[TB] FAIL b2b_wr_rate writes=%0d span=%0d exp 4/6", done, last_hs - first_hs);
    end
    arprot = 3'b001; araddr = 32'(8 * 4); arvalid = 1'b1; rready = 1'b1;
    edges = 0; done = 0; first_hs = 0; last_hs = 0;
    while (done < 4 && edges < 40) begin
      go = arready;
      @(posedge aclk); #1;
      edges++;
      if (go) begin
        checks++;
        if (rdata !== model[8 + done] || rresp !== 2'b00) begin
          failures++; $display("[TB] FAIL b2b_rd %0d rdata=%h exp %h", done, rdata, model[8 + done]);
        end
        if (done == 0) first_hs = edges;
        last_hs = edges;
        done++;
        if (done < 4) araddr = 32'((8 + done) * 4);
      end
    end
    arvalid = 1'b0;
    @(posedge aclk); #1;
    rready = 1'b0;
    checks++;
    if (done != 4 || last_hs - first_hs != 6) begin
      failures++; $display("[TB] FAIL b2b_rd_rate reads=%0d span=%0d exp 4/6", done, last_hs - first_hs);
    end
  endtask

`ifdef S_AXI_PROT_CHECK_EN
  task automatic test_prot();
    logic [1:0] resp; logic [NUM_REGS-1:0] p, pa; bit to; logic [31:0] d;
    axi_write(32'h00, 32'h11223344, 4'hF, 3'b000, resp, p, pa, to);
    checks++;
    if (to || resp !== 2'b10 || p !== '0 || reg_of(0) !== model[0]) begin
      failures++; $display("[TB] FAIL prot_unpriv bresp=%b pulse=%h reg0=%h exp 10/0/%h", resp, p, reg_of(0), model[0]);
    end
    axi_write(32'h00, 32'h11223344, 4'hF, 3'b001, resp, p, pa, to);
    model[0] = 32'h11223344;
    checks++;
    if (to || resp !== 2'b00 || reg_of(0) !== model[0]) begin
      failures++; $display("[TB] FAIL prot_priv bresp=%b reg0=%h exp 00/%h", resp, reg_of(0), model[0]);
    end
    axi_read(32'h00, 3'b000, d, resp, to);
    checks++;
    if (to || d !== 32'h0 || resp !== 2'b10) begin
      failures++; $display("[TB] FAIL prot_read rdata=%h rresp=%b exp 0/10", d, resp);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_same_cycle();
    test_write_data_first();
    test_read_stall();
    test_out_of_range();
    test_concurrent();
    test_reset_mid();
    test_random();
    test_back_to_back();
`ifdef S_AXI_PROT_CHECK_EN
    test_prot();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/s_axi_regfile.md
# s_axi_regfile

AXI4-Lite slave (responder) exposing `NUM_REGS` 32-bit read/write registers to a bus master such as the tDMA master controller. Accepts write address and write data independently in either order, commits with byte strobes, and returns B/R responses with SLVERR on out-of-range addresses. Register contents drive fabric-side configuration outputs, with a one-cycle write pulse per register.

## Interface
Parameters:
- NUM_REGS, 16, number of 32-bit registers (2..256)
- ADDR_W, 32, AXI address width

Ports:
- aclk_i  in  1  clock
- aresetn_i  in  1  asynchronous active-low reset
- awvalid_i / awready_o  in/out  1  write-address handshake
- awaddr_i  in  ADDR_W  write byte address
- awprot_i  in  3  write protection
- wvalid_i / wready_o  in/out  1  write-data handshake
- wdata_i  in  32  write data
- wstrb_i  in  4  byte strobes
- bvalid_o / bready_i  out/in  1  write-response handshake
- bresp_o  out  2  write response
- arvalid_i / arready_o  in/out  1  read-address handshake
- araddr_i  in  ADDR_W  read byte address
- arprot_i  in  3  read protection
- rvalid_o / rready_i  out/in  1  read-data handshake
- rdata_o  out  32  read data
- rresp_o  out  2  read response
- regs_o  out  NUM_REGS*32  register contents, register k at [32k+:32]
- reg_wr_o  out  NUM_REGS  one-cycle pulse on register k commit

## Operation
- Decode: index = addr[2 +: clog2(NUM_REGS)]; addr[1:0] ignored; addr ≥ NUM_REGS*4 → out of range.
- Write FSM: W_IDLE, W_ADDR (address held), W_DATA (data held), W_RESP.
  - awready_o = W_IDLE or W_DATA; wready_o = W_IDLE or W_ADDR.
  - W_IDLE: AW+W same cycle → commit, W_RESP; AW only → latch, W_ADDR; W only → latch, W_DATA.
  - W_ADDR + W handshake, or W_DATA + AW handshake → commit, W_RESP.
  - W_RESP: bvalid_o=1; bready_i → W_IDLE.
- Commit: per-byte write where wstrb_i bit set; reg_wr_o[k] pulses even when wstrb_i=0; bresp OKAY (2'b00). Out of range: no write, no pulse, bresp SLVERR (2'b10).
- Read FSM: R_IDLE (arready_o=1), R_RESP (rvalid_o=1). AR handshake captures rdata_o/rresp_o; rready_i → R_IDLE. Out of range: rdata_o=0, SLVERR.
- Read and write FSMs independent; both may be active the same cycle.

## Timing
- Reset (aresetn_i low, async): registers, regs_o, reg_wr_o, bvalid_o, rvalid_o, rdata_o, bresp_o, rresp_o all 0; FSMs idle; awready_o, wready_o, arready_o forced 0 while reset asserted, 1 the first cycle after release.
- Write: handshake completing at edge N updates regs_o at edge N; reg_wr_o high cycle N..N+1; bvalid_o high from edge N until bready_i sampled.
- Read: AR at edge N → rvalid_o/rdata_o valid from edge N; max throughput one read per 2 cycles, one write per 2 cycles.
- bvalid_o, rdata_o, rresp_o stable while rvalid_o/bvalid_o high and not accepted.
- Same-register read and write committing the same edge: read returns the old value.
- Reset mid-transaction: pending response dropped, latched address/data discarded.

## Configuration
- S_AXI_PROT_CHECK_EN defined: awprot_i[0]=0 or arprot_i[0]=0 (unprivileged) → SLVERR, write suppressed, rdata 0; protection bits latched with the address.
- Undefined: awprot_i/arprot_i ignored.

## Structure
- Package s_axi_pkg: resp constants OKAY=2'b00, SLVERR=2'b10; write/read state enums.
- Sub-module s_axi_reg_bank: NUM_REGS registers with byte-strobe write port, write pulse and combinational read mux.

## Test plan
- Reset, then AW+W same cycle addr 0x04, data 0xDEADBEEF, strb 0xF → regs_o[1]=0xDEADBEEF, reg_wr_o[1] one cycle, bresp 00.
- W at cycle 0, AW addr 0x08 at cycle 3, strb 0x3, data 0x12345678 over 0xFFFFFFFF → reg2=0xFFFF5678; bvalid held 4 cycles with bready low.
- Read addr 0x04 after first write → rdata 0xDEADBEEF, rresp 00; rready held low 3 cycles, rdata stable.
- Write/read addr NUM_REGS*4 → bresp 10, no reg_wr_o pulse; rdata 0, rresp 10.
- Concurrent read and write to addr 0x0C, old 0x1, new 0x2 → rdata 0x1, reg3=0x2.
- With S_AXI_PROT_CHECK_EN, awprot 3'b000 write to 0x00 → bresp 10, reg0 unchanged; awprot 3'b001 → OKAY.
